// File: rtl/mem_bus_master.sv
// Memory bus initiator: queued load/store requests become bus read/write cycles.
// Define MEM_BUS_WRITE_VERIFY_EN to read back and compare every aligned store.
module mem_bus_master #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 16,
    parameter int READ_LAT   = 1,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] address_bus,
    inout  wire  [DATA_W-1:0] data_bus,
    output logic              write_mode
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    typedef enum logic [2:0] {
        IDLE, CHECK, WRITE, TURN, READ, RESP
    } state_t;

    state_t state, next_state;

    logic              f_write [FIFO_DEPTH];
    logic [ADDR_W-1:0] f_addr  [FIFO_DEPTH];
    logic [DATA_W-1:0] f_wdata [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;

    logic              h_write;
    logic [ADDR_W-1:0] h_addr;
    logic [DATA_W-1:0] h_wdata;
    logic              last_wr;
    logic [LAT_W-1:0]  lat_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic push, pop, read_done;

    assign req_ready = (count != CNT_W'(FIFO_DEPTH));
    assign push      = req_valid && req_ready;
    assign pop       = (state == IDLE) && (count != '0);
    assign read_done = (state == READ) && (lat_cnt == LAT_W'(READ_LAT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                f_write[wr_ptr] <= req_write;
                f_addr[wr_ptr]  <= req_addr;
                f_wdata[wr_ptr] <= req_wdata;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:  if (count != '0) next_state = CHECK;
            CHECK: begin
                if (h_addr[0])    next_state = RESP;
                else if (h_write) next_state = WRITE;
                else if (last_wr) next_state = TURN;
                else              next_state = READ;
            end
`ifdef MEM_BUS_WRITE_VERIFY_EN
            WRITE: next_state = TURN;
`else
            WRITE: next_state = RESP;
`endif
            TURN:  next_state = READ;
            READ:  if (read_done) next_state = RESP;
            RESP:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            h_write <= 1'b0;
            h_addr  <= '0;
            h_wdata <= '0;
            last_wr <= 1'b0;
            lat_cnt <= '0;
            addr_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= next_state;
            if (pop) begin
                h_write <= f_write[rd_ptr];
                h_addr  <= f_addr[rd_ptr];
                h_wdata <= f_wdata[rd_ptr];
                rdata_q <= '0;
                err_q   <= 1'b0;
            end
            if (state == CHECK && h_addr[0]) err_q <= 1'b1;
            // Bus address only moves when a real bus cycle starts.
            if (next_state == WRITE || next_state == READ) addr_q <= h_addr;
            if (state == WRITE) last_wr <= 1'b1;
            if (state == READ)  last_wr <= 1'b0;
            lat_cnt <= (state == READ) ? lat_cnt + 1'b1 : '0;
            if (read_done) begin
                rdata_q <= data_bus;
`ifdef MEM_BUS_WRITE_VERIFY_EN
                err_q   <= h_write && (data_bus != h_wdata);
`endif
            end
        end
    end

    assign rsp_valid   = (state == RESP);
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;
    assign address_bus = addr_q;
    assign write_mode  = (state == WRITE);
    assign data_bus    = write_mode ? h_wdata : {DATA_W{1'bz}};

endmodule

// File: tb/tb_mem_bus_master.sv
// Bench for mem_bus_master: memory responder, in-order response model.
// Covers default build and MEM_BUS_WRITE_VERIFY_EN.
module tb_mem_bus_master;

    parameter int READ_LAT = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [11:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    wire         req_ready;
    wire         rsp_valid;
    wire  [15:0] rsp_rdata;
    wire         rsp_err;
    wire  [11:0] address_bus;
    wire  [15:0] data_bus;
    wire         write_mode;

    mem_bus_master #(
        .ADDR_W(12), .DATA_W(16), .READ_LAT(READ_LAT), .FIFO_DEPTH(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .address_bus(address_bus), .data_bus(data_bus),
        .write_mode(write_mode)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] seed_val(input int i);
        return 16'(i * 40503) ^ 16'h5a5a;
    endfunction

    // Memory responder; stuck_en forces reads of 0x020 to 0x1234
    logic [15:0] mem [2048];
    logic        mem_init = 1'b1;
    logic        stuck_en = 1'b0;
    wire  [15:0] mem_rd = (stuck_en && address_bus == 12'h020) ? 16'h1234
                          : mem[address_bus[11:1]];
    assign data_bus = write_mode ? 16'hzzzz : mem_rd;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 2048; i++) mem[i] <= seed_val(i);
        end else if (write_mode) begin
            mem[address_bus[11:1]] <= data_bus;
        end
    end

    typedef struct packed {
        logic [15:0] rdata;
        logic        err;
        int          lat;
        int          t0;
    } exp_t;

    exp_t        q[$];
    logic [15:0] shadow [2048];
    bit          prev_wr = 1'b0;
    int          cyc = 0;
    int          compared = 0;
    int          mismatched = 0;
    int          n_wr = 0;
    int          exp_wr = 0;
    logic [11:0] last_wa = '0;
    logic [15:0] last_wd = '0;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && write_mode) begin
            n_wr++;
            last_wa = address_bus;
            last_wd = data_bus;
        end
        if (rst_n && rsp_valid) begin
            if (q.size() == 0) begin
                chk("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
                if (e.lat >= 0) chk("rsp_latency", cyc - e.t0, e.lat);
            end
        end
    end

    // Expected response is fixed at push time: requests complete in order
    task automatic push(input logic w, input logic [11:0] a,
                        input logic [15:0] d, input bit chk_lat);
        int          n;
        exp_t        e;
        logic [15:0] rb;
        n = 0;
        while (!req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("req_ready_timeout", 32'd0, 32'd1);
            return;
        end
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        @(posedge clk);
        #1;
        e.t0 = cyc;
        e.rdata = '0;
        e.err = 1'b0;
        e.lat = -1;
        rb = '0;
        if (a[0]) begin
            e.err = 1'b1;
            if (chk_lat) e.lat = 2;
        end else if (w) begin
            shadow[a[11:1]] = d;
            exp_wr++;
`ifdef MEM_BUS_WRITE_VERIFY_EN
            rb = (stuck_en && a == 12'h020) ? 16'h1234 : d;
            e.rdata = rb;
            e.err = (rb != d);
            prev_wr = 1'b0;
            if (chk_lat) e.lat = 4 + READ_LAT;
`else
            prev_wr = 1'b1;
            if (chk_lat) e.lat = 3;
`endif
        end else begin
            e.rdata = shadow[a[11:1]];
            if (chk_lat) e.lat = 2 + READ_LAT + (prev_wr ? 1 : 0);
            prev_wr = 1'b0;
        end
        q.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [11:0] a_before;
        int          w_before;
        logic [11:0] ra;
        for (int i = 0; i < 2048; i++) shadow[i] = seed_val(i);

        repeat (3) @(negedge clk);
        mem_init = 1'b0;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_write_mode", 32'(write_mode), 32'd0);
        chk("rst_address_bus", 32'(address_bus), 32'd0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Store abandoned by reset before its WRITE edge
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 12'h100;
        req_wdata = 16'hbeef;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_write_mode", 32'(write_mode), 32'd0);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_req_ready", 32'(req_ready), 32'd1);
        chk("abort_address_bus", 32'(address_bus), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort_no_write", n_wr, 0);
        push(1'b0, 12'h100, 16'h0, 1'b1);
        drain();

        // Store then load of the same word
        push(1'b1, 12'hffe, 16'haaaa, 1'b1);
        drain();
        chk("wr_addr", 32'(last_wa), 32'hffe);
        chk("wr_data", 32'(last_wd), 32'haaaa);
        push(1'b0, 12'hffe, 16'h0, 1'b1);
        drain();

        // Back-to-back stores fill the queue
        push(1'b1, 12'hffc, 16'hbbbb, 1'b0);
        push(1'b1, 12'hffa, 16'hcccc, 1'b0);
        push(1'b1, 12'hff8, 16'hdddd, 1'b0);
        chk("ready_full", 32'(req_ready), 32'd0);
        push(1'b0, 12'hffc, 16'h0, 1'b0);
        drain();
        chk("b2b_last_wr_addr", 32'(last_wa), 32'hff8);

        // Misaligned load: no bus cycle
        a_before = address_bus;
        w_before = n_wr;
        push(1'b0, 12'h0ff1, 16'h0, 1'b1);
        drain();
        chk("misalign_addr_hold", 32'(address_bus), 32'(a_before));
        chk("misalign_no_write", n_wr, w_before);

`ifdef MEM_BUS_WRITE_VERIFY_EN
        stuck_en = 1'b1;
        push(1'b1, 12'h020, 16'h5678, 1'b1);
        drain();
        stuck_en = 1'b0;
`endif

        for (int k = 0; k < 80; k++) begin
            ra = 12'($urandom_range(0, 31)) << 1;
            ra[0] = ($urandom % 8 == 0);
            push(1'($urandom % 2), ra, 16'($urandom), 1'b0);
            repeat ($urandom % 3) @(negedge clk);
        end
        drain();
        chk("write_count", n_wr, exp_wr);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
